// File: rtl/car_pkg.sv
// Shared definitions for the car controllers: 4-bit state codes and default timing.
package car_pkg;

   typedef enum logic [3:0] {
      ST_OFF     = 4'b0000,
      ST_NO_ST   = 4'b0011,
      ST_START   = 4'b0111,
      ST_MOVEF   = 4'b0110,
      ST_MOVEB   = 4'b0101,
      // codes owned by the semi-auto controller
      ST_SA_1000 = 4'b1000,
      ST_SA_1001 = 4'b1001,
      ST_SA_1010 = 4'b1010,
      ST_SA_1011 = 4'b1011,
      ST_SA_1110 = 4'b1110,
      ST_SA_1111 = 4'b1111
   } car_state_e;

   localparam int PWR_HOLD_DEF  = 100_000_000;
   localparam int DB_CYC_DEF    = 2_000_000;
   localparam int MILE_TICK_DEF = 10_000_000;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stable-count filter on one raw input.
module debounce
   import car_pkg::*;
#(
   parameter int DB_CYC = DB_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level
);

   localparam int                CNT_W   = $clog2(DB_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYC - 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         // level flips only after DB_CYC consecutive disagreeing samples
         if (r_sync[1] != r_level) begin
            if (r_cnt == CNT_MAX) begin
               r_level <= r_sync[1];
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/car_state_ctrl.sv
// Manual-driving controller: debounced driver controls to car state code,
// plus mileage counting and turn indicators.
//
//   state | meaning
//   OFF   | powered down, waiting for a long power-button hold
//   NO_ST | powered, engine not started
//   START | engine running, not moving
//   MOVEF | moving forward
//   MOVEB | moving in reverse
module car_state_ctrl
   import car_pkg::*;
#(
   parameter int PWR_HOLD  = PWR_HOLD_DEF,
   parameter int DB_CYC    = DB_CYC_DEF,
   parameter int MILE_TICK = MILE_TICK_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        power_btn,
   input  logic        throttle,
   input  logic        clutch,
   input  logic        brake,
   input  logic        reverse,
   input  logic        turn_left,
   input  logic        turn_right,
   output logic [3:0]  state,
   output logic [23:0] mileage,
   output logic [1:0]  turn_led
);

   localparam int               HOLD_W   = $clog2(PWR_HOLD + 1);
   localparam int               TICK_W   = $clog2(MILE_TICK + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(PWR_HOLD - 1);
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(MILE_TICK - 1);

   logic [6:0] w_raw;
   logic [6:0] w_db;
   logic       w_pb, w_th, w_cl, w_br, w_rv, w_tl, w_tr;

   assign w_raw = {power_btn, throttle, clutch, brake, reverse, turn_left, turn_right};
   assign {w_pb, w_th, w_cl, w_br, w_rv, w_tl, w_tr} = w_db;

   for (genvar g = 0; g < 7; g++) begin : g_db
      debounce #(.DB_CYC(DB_CYC)) u_db (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_raw   (w_raw[g]),
         .o_level (w_db[g])
      );
   end

   car_state_e        r_state;
   car_state_e        w_next;
   logic              r_pb_d;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [TICK_W-1:0] r_tick_cnt;
   logic [23:0]       r_mileage;
   logic [1:0]        r_turn_led;

   logic       w_pb_rise;
   logic       w_mismatch;
   logic       w_moving;
   logic       w_hold_done;
   logic [1:0] w_led_d;

   assign w_pb_rise   = w_pb && !r_pb_d;
   assign w_hold_done = w_pb && (r_hold_cnt == HOLD_MAX);
   assign w_mismatch  = (r_state == ST_MOVEF) ? w_rv : !w_rv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_OFF;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      // a fresh press powers off from anywhere; the held press after power-on is not an edge
      if (r_state != ST_OFF && w_pb_rise) begin
         w_next = ST_OFF;
      end else begin
         case (r_state)
            ST_OFF:   if (w_hold_done) w_next = ST_NO_ST;
            ST_NO_ST: begin
               if (w_th && !w_cl)     w_next = ST_OFF;
               else if (w_th && w_cl) w_next = ST_START;
            end
            ST_START: begin
               if (w_br && !w_th)                w_next = ST_NO_ST;
               else if (w_th && !w_cl && !w_br)  w_next = w_rv ? ST_MOVEB : ST_MOVEF;
            end
            ST_MOVEF, ST_MOVEB: begin
               if (w_mismatch && !w_cl)  w_next = ST_OFF;
               else if (w_br)            w_next = ST_NO_ST;
               else if (w_cl || !w_th)   w_next = ST_START;
            end
            default:  w_next = ST_OFF;
         endcase
      end
   end

   always_comb begin
      w_moving = (r_state == ST_MOVEF) || (r_state == ST_MOVEB);
      w_led_d  = (w_next == ST_OFF) ? 2'b00 : {w_tl, w_tr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pb_d     <= 1'b0;
         r_hold_cnt <= '0;
         r_tick_cnt <= '0;
         r_mileage  <= '0;
         r_turn_led <= '0;
      end else begin
         r_pb_d     <= w_pb;
         r_turn_led <= w_led_d;

         if (r_state == ST_OFF && w_pb && !w_hold_done) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
         else                                            r_hold_cnt <= '0;

         if (w_next == ST_OFF) begin
            r_tick_cnt <= '0;
            r_mileage  <= '0;
         end else if (w_moving) begin
            if (r_tick_cnt == TICK_MAX) begin
               r_tick_cnt <= '0;
               if (r_mileage != 24'hFF_FFFF) r_mileage <= r_mileage + 24'd1;
            end else begin
               r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
         end
      end
   end

   assign state    = r_state;
   assign mileage  = r_mileage;
   assign turn_led = r_turn_led;

endmodule

// File: tb/tb_car_state_ctrl.sv
// Scoreboard bench for car_state_ctrl with short timing constants.
module tb_car_state_ctrl;

   localparam int PWR_HOLD  = 16;
   localparam int DB_CYC    = 4;
   localparam int MILE_TICK = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        power_btn = 1'b0;
   logic        throttle = 1'b0;
   logic        clutch = 1'b0;
   logic        brake = 1'b0;
   logic        reverse = 1'b0;
   logic        turn_left = 1'b0;
   logic        turn_right = 1'b0;
   logic [3:0]  state;
   logic [23:0] mileage;
   logic [1:0]  turn_led;

   always #5 clk = ~clk;

   car_state_ctrl #(
      .PWR_HOLD  (PWR_HOLD),
      .DB_CYC    (DB_CYC),
      .MILE_TICK (MILE_TICK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .power_btn  (power_btn),
      .throttle   (throttle),
      .clutch     (clutch),
      .brake      (brake),
      .reverse    (reverse),
      .turn_left  (turn_left),
      .turn_right (turn_right),
      .state      (state),
      .mileage    (mileage),
      .turn_led   (turn_led)
   );

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic        use_model;
      logic [23:0] mi;
      logic [1:0]  led;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   moving  = 0;
   logic [3:0] mon_old;

   // reference mileage: cycles spent moving since the last OFF
   always @(posedge clk) begin
      mon_old = state;
      #1;
      if (!rst_n) moving = 0;
      else begin
         if (mon_old == 4'b0110 || mon_old == 4'b0101) moving++;
         if (state == 4'b0000) moving = 0;
      end
   end

   function automatic logic [23:0] model_mi();
      int m;
      m = moving / MILE_TICK;
      return (m > 24'hFF_FFFF) ? 24'hFF_FFFF : m[23:0];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [3:0] st, input logic use_model,
                           input logic [23:0] mi, input logic [1:0] led);
      exp_t e;
      e.tag = tag; e.st = st; e.use_model = use_model; e.mi = mi; e.led = led;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input int settle, input int budget);
      exp_t e;
      int   n;
      repeat (settle) @(negedge clk);
      e = sb.pop_front();
      n = 0;
      while (state !== e.st && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val({e.tag, "_state"}, 32'(state), 32'(e.st));
      check_val({e.tag, "_mile"}, 32'(mileage), e.use_model ? 32'(model_mi()) : 32'(e.mi));
      check_val({e.tag, "_led"}, 32'(turn_led), 32'(e.led));
   endtask

   task automatic power_on(input string tag);
      power_btn = 1'b1;
      push_exp(tag, 4'b0011, 1'b1, '0, 2'b00);
      pop_cmp(0, 40);
      power_btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic start_move(input string tag, input logic [3:0] mv);
      throttle = 1'b1;
      clutch   = 1'b1;
      push_exp({tag, "_start"}, 4'b0111, 1'b1, '0, 2'b00);
      pop_cmp(0, 15);
      clutch = 1'b0;
      push_exp({tag, "_move"}, mv, 1'b1, '0, 2'b00);
      pop_cmp(0, 15);
   endtask

   initial begin
      int n;
      #1;
      push_exp("reset", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(0, 0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // a press shorter than the hold time does nothing
      power_btn = 1'b1;
      repeat (10) @(negedge clk);
      power_btn = 1'b0;
      push_exp("short_press", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(40, 0);

      // power-on latency: sync 2 + debounce 4 + hold 16
      power_btn = 1'b1;
      n = 0;
      while (state !== 4'b0011 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_val("pwr_latency", 32'(n), 32'(2 + DB_CYC + PWR_HOLD));
      if (n < 30) repeat (30 - n) @(negedge clk);
      power_btn = 1'b0;
      push_exp("pwr_release", 4'b0011, 1'b0, 24'd0, 2'b00);
      pop_cmp(20, 0);

      // 80 moving cycles: 73 here plus 7 for brake to propagate
      start_move("fwd1", 4'b0110);
      repeat (73) @(negedge clk);
      brake    = 1'b1;
      throttle = 1'b0;
      push_exp("brake", 4'b0011, 1'b0, 24'd10, 2'b00);
      pop_cmp(0, 15);
      push_exp("mile_hold", 4'b0011, 1'b0, 24'd10, 2'b00);
      pop_cmp(20, 0);
      brake = 1'b0;
      repeat (8) @(negedge clk);

      power_btn = 1'b1;
      push_exp("pwr_off", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(0, 15);
      power_btn = 1'b0;
      repeat (10) @(negedge clk);

      // indicators and glitch rejection while moving forward
      power_on("pwr_on2");
      start_move("fwd2", 4'b0110);
      turn_left = 1'b1;
      push_exp("led_left", 4'b0110, 1'b1, '0, 2'b10);
      pop_cmp(10, 0);
      brake = 1'b1;
      repeat (2) @(negedge clk);
      brake = 1'b0;
      push_exp("brake_glitch", 4'b0110, 1'b1, '0, 2'b10);
      pop_cmp(15, 0);
      turn_left = 1'b0;
      repeat (8) @(negedge clk);

      reverse = 1'b1;
      push_exp("gear_fault", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(0, 15);
      turn_left  = 1'b1;
      turn_right = 1'b1;
      push_exp("led_in_off", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(12, 0);
      turn_left  = 1'b0;
      turn_right = 1'b0;
      reverse    = 1'b0;
      throttle   = 1'b0;
      repeat (10) @(negedge clk);

      power_on("pwr_on3");
      throttle = 1'b1;
      push_exp("stall", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(0, 15);
      throttle = 1'b0;
      repeat (10) @(negedge clk);

      // reverse drive, throttle+brake hold in START, then async reset
      power_on("pwr_on4");
      throttle = 1'b1;
      clutch   = 1'b1;
      push_exp("rev_start", 4'b0111, 1'b1, '0, 2'b00);
      pop_cmp(0, 15);
      brake = 1'b1;
      push_exp("th_br_hold", 4'b0111, 1'b1, '0, 2'b00);
      pop_cmp(15, 0);
      brake   = 1'b0;
      reverse = 1'b1;
      repeat (10) @(negedge clk);
      clutch = 1'b0;
      push_exp("moveb", 4'b0101, 1'b1, '0, 2'b00);
      pop_cmp(0, 15);
      turn_right = 1'b1;
      push_exp("led_right", 4'b0101, 1'b1, '0, 2'b01);
      pop_cmp(30, 0);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      push_exp("async_rst", 4'b0000, 1'b0, 24'd0, 2'b00);
      pop_cmp(0, 0);
      #20;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
